nv_nvdla_hs4_tx: RTL and testbench
==================================

# nv_nvdla_hs4_tx

Source-domain transmitter for a 4-phase req/ack handshake that carries single-cycle event pulses across a clock boundary. It converts event pulses into a level request (`req_o`), which the destination domain captures through its own 3-flop level synchronizer. It then waits for the destination's returned acknowledge level, which this block synchronizes internally with a 3-flop chain. Events that arrive while a handshake is in flight are queued in a saturating pending counter, so bursts are delivered one handshake per event and none are silently dropped.

## Interface
- `CNT_W`, default 4: width of the pending-event counter; max queued events = 2^CNT_W − 1.

- `nvdla_core_clk`  in  1  source-domain clock; the only clock in the block.
- `nvdla_core_rstn`  in  1  reset, asynchronous assert, active-low.
- `evt_pulse`  in  1  single-cycle event to transmit; each high cycle is one event.
- `ack_i`  in  1  acknowledge level from the destination domain; asynchronous, never used before the internal sync.
- `ovf_clr`  in  1  clears sticky `ovf`.
- `req_o`  out  1  4-phase request level, driven directly from a flop (glitch-free for CDC).
- `busy`  out  1  high when a handshake is in flight or events are pending.
- `pend_cnt`  out  CNT_W  count of events accepted but not yet launched.
- `ovf`  out  1  sticky flag: an event was lost because the counter was saturated.

## Operation
- Ack sync: `ack_i` → s1 → s2 → s3 (`ack_s`), all clocked by `nvdla_core_clk` and reset to 0.
- FSM states: IDLE, REQ, REL.
  - IDLE → REQ when `pend_cnt` != 0 and `ack_s` == 0. The transition sets `req_o` = 1 and decrements `pend_cnt`.
  - IDLE with `ack_s` == 1 stays in IDLE. This guards against a stale ack after reset.
  - REQ → REL when `ack_s` == 1. The transition sets `req_o` = 0.
  - REL → IDLE when `ack_s` == 0.
  - There are no other transitions. The FSM has no timeout.
- `pend_cnt` update in a cycle, where inc = `evt_pulse`, dec = IDLE→REQ launch:
  - inc & !dec: +1 if below max. At max, it holds and sets `ovf`.
  - dec & !inc: −1.
  - inc & dec: unchanged. This is not an overflow, even at max.
- `ovf`: set has priority over `ovf_clr` in the same cycle. `ovf_clr` alone clears it on the next edge.
- `busy` = (state != IDLE) | (`pend_cnt` != 0). This is combinational from flops.
- Reset values: state = IDLE; `req_o` = 0; `pend_cnt` = 0; `ovf` = 0; s1/s2/s3 = 0; `busy` = 0.
- Reset mid-handshake: `req_o` drops asynchronously and queued events are discarded. If the destination still holds ack high, no new request launches until `ack_s` returns to 0.

## Timing
- Event to request: `evt_pulse` high in cycle 0 with the block idle and `ack_s` = 0 gives `pend_cnt` = 1 in cycle 1, then `req_o` = 1 and `pend_cnt` = 0 in cycle 2.
- Ack to request drop: `ack_i` first sampled high at the end of cycle k gives `ack_s` = 1 in cycle k+3, then `req_o` = 0 in cycle k+4.
- Ack release to IDLE: `ack_i` first sampled low at the end of cycle m gives `ack_s` = 0 in cycle m+3 and state IDLE in cycle m+4. If `pend_cnt` != 0, the next request launches with `req_o` = 1 in cycle m+5.
- `req_o` changes only on FSM transitions. It never toggles twice without an intervening `ack_s` change.
- Throughput: one event per complete 4-phase round trip.

## Test plan
- Reset check: apply reset with random inputs → `req_o` = 0, `pend_cnt` = 0, `ovf` = 0, `busy` = 0. Asserting `ack_i` = 1 during reset release → no request until `ack_i` drops and 3 cycles elapse.
- Single event with a responder model (ack = req delayed 5 cycles through a 3-flop sync) → `req_o` rises in cycle 2 and falls exactly 4 cycles after `ack_i` is sampled high. Exactly one handshake occurs, then `busy` = 0.
- Burst of 6 consecutive `evt_pulse` cycles, `CNT_W` = 4 → `pend_cnt` peaks at 5 (one event launches immediately). Exactly 6 handshakes complete, then `pend_cnt` = 0 and `ovf` = 0.
- Overflow, `CNT_W` = 2, ack held low: send 5 events → 1 in flight, `pend_cnt` saturates at 3, `ovf` = 1. `ovf_clr` together with a new dropped event → `ovf` stays 1. `ovf_clr` alone → `ovf` = 0.
- Simultaneous `evt_pulse` and launch with `pend_cnt` = max → `pend_cnt` unchanged, `ovf` = 0.
- Reset asserted in REQ state with `ack_i` = 1 → `req_o` = 0 immediately. After release, `req_o` stays 0 until `ack_i` = 0 propagates through the sync.

Source files
------------

// File: rtl/nv_nvdla_hs4_tx_if.sv
// nv_nvdla_hs4_tx_if: event/handshake bundle between an event source and the hs4 transmitter
interface nv_nvdla_hs4_tx_if #(
    parameter int CNT_W = 4
);
    logic             evt_pulse;
    logic             ack_i;
    logic             ovf_clr;
    logic             req_o;
    logic             busy;
    logic [CNT_W-1:0] pend_cnt;
    logic             ovf;

    modport master (
        output evt_pulse, ack_i, ovf_clr,
        input  req_o, busy, pend_cnt, ovf
    );

    modport slave (
        input  evt_pulse, ack_i, ovf_clr,
        output req_o, busy, pend_cnt, ovf
    );
endinterface

// File: rtl/nv_nvdla_hs4_tx.sv
// nv_nvdla_hs4_tx: source side of a 4-phase req/ack handshake that queues event pulses
module nv_nvdla_hs4_tx #(
    parameter int CNT_W = 4
) (
    input logic              nvdla_core_clk,
    input logic              nvdla_core_rstn,
    nv_nvdla_hs4_tx_if.slave hs
);
    localparam logic [1:0]       IDLE    = 2'd0;
    localparam logic [1:0]       REQ     = 2'd1;
    localparam logic [1:0]       REL     = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             s1;
    logic             s2;
    logic             ack_s;
    logic             req;
    logic             ovf;
    logic [CNT_W-1:0] cnt;
    logic             launch;
    logic             at_max;

    // three-flop synchronizer for the acknowledge level coming from the destination clock
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn)
        if (!nvdla_core_rstn) {ack_s, s2, s1} <= 3'b000;
        else {ack_s, s2, s1} <= {s2, s1, hs.ack_i};

    assign launch = (state == IDLE) && (cnt != '0) && !ack_s;
    assign at_max = (cnt == CNT_MAX);

    // idle only launches once ack is low, so a stale ack left over from a reset cannot complete a request
    always_comb
        state_nxt = (state == IDLE) ? (launch ? REQ : IDLE) :
                    (state == REQ)  ? (ack_s ? REL : REQ) :
                                      (ack_s ? REL : IDLE);

    // req is a flop tracking the state being entered, so it only moves on handshake transitions
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn)
        if (!nvdla_core_rstn) begin
            state <= IDLE;
            req   <= 1'b0;
        end else begin
            state <= state_nxt;
            req   <= (state_nxt == REQ);
        end

    // saturating pending count; an event arriving with no room and no simultaneous launch is lost
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn)
        if (!nvdla_core_rstn) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            if (hs.evt_pulse && !launch && !at_max) cnt <= cnt + 1'b1;
            else if (launch && !hs.evt_pulse) cnt <= cnt - 1'b1;
            if (hs.evt_pulse && !launch && at_max) ovf <= 1'b1;
            else if (hs.ovf_clr) ovf <= 1'b0;
        end

    assign hs.req_o    = req;
    assign hs.busy     = (state != IDLE) || (cnt != '0);
    assign hs.pend_cnt = cnt;
    assign hs.ovf      = ovf;
endmodule

// File: tb/tb_nv_nvdla_hs4_tx.sv
// tb_nv_nvdla_hs4_tx: randomized and directed checks of the hs4 transmitter against a handshake model
module tb_nv_nvdla_hs4_tx;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int tests = 0;
    int fails = 0;
    bit resp_on = 1'b0;
    logic [4:0] hist = '0;
    int m_phase;
    int m_cnt;
    bit m_ovf;
    logic [2:0] m_ah;

    always #5 clk = ~clk;

    nv_nvdla_hs4_tx_if #(.CNT_W(4)) hs4();
    nv_nvdla_hs4_tx_if #(.CNT_W(2)) hs2();

    nv_nvdla_hs4_tx #(.CNT_W(4)) u4 (.nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .hs(hs4.slave));
    nv_nvdla_hs4_tx #(.CNT_W(2)) u2 (.nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .hs(hs2.slave));

    task automatic model_reset();
        m_phase = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
        m_ah = '0;
    endtask

    // phase 0 = waiting, 1 = request raised, 2 = request dropped awaiting ack release
    task automatic model_step(bit e, bit a, bit c);
        bit ack_s;
        bit launch;
        int n;
        ack_s = m_ah[2];
        launch = (m_phase == 0) && (m_cnt > 0) && !ack_s;
        n = m_cnt + int'(e) - int'(launch);
        if (n > 15) begin
            n = 15;
            m_ovf = 1'b1;
        end else if (c) m_ovf = 1'b0;
        if (m_phase == 0 && launch) m_phase = 1;
        else if (m_phase == 1 && ack_s) m_phase = 2;
        else if (m_phase == 2 && !ack_s) m_phase = 0;
        m_cnt = n;
        m_ah = {m_ah[1:0], a};
    endtask

    // advance one cycle; outputs are looked at 1 ns after the edge, the responder acks req 5 cycles late
    task automatic tick();
        bit e, a, c;
        e = hs4.evt_pulse;
        a = hs4.ack_i;
        c = hs4.ovf_clr;
        @(posedge clk);
        #1;
        if (rstn) model_step(e, a, c);
        if (resp_on) begin
            hist = {hist[3:0], hs4.req_o};
            hs4.ack_i = hist[4];
        end
    endtask

    task automatic drain();
        int c;
        if (!resp_on) begin
            hist = '0;
            resp_on = 1'b1;
        end
        hs4.evt_pulse = 1'b0;
        c = 0;
        while (hs4.busy && c < 600) begin
            tick();
            c++;
        end
        tests++;
        if (hs4.busy !== 1'b0) begin
            fails++;
            $display("FAIL drain_timeout: busy=%0b after %0d cycles, want 0", hs4.busy, c);
        end
        for (int i = 0; i < 10; i++) tick();
    endtask

    // called right after reset release with ack_i held high and no events pending
    task automatic stale_ack_release(string tag);
        for (int i = 0; i < 3; i++) tick();
        hs4.evt_pulse = 1'b1;
        tick();
        hs4.evt_pulse = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (hs4.req_o !== 1'b0 || hs4.pend_cnt !== 4'd1) begin
                fails++;
                $display("FAIL %s_stale_hold: req=%0b pend=%0d, want req=0 pend=1", tag, hs4.req_o, hs4.pend_cnt);
            end
        end
        hs4.ack_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            tests++;
            if (hs4.req_o !== (i == 4)) begin
                fails++;
                $display("FAIL %s_stale_release: cycle m+%0d req=%0b, want %0b", tag, i, hs4.req_o, i == 4);
            end
        end
        tests++;
        if (hs4.pend_cnt !== 4'd0 || hs4.req_o !== (m_phase == 1)) begin
            fails++;
            $display("FAIL %s_stale_model: pend=%0d req=%0b, want pend=0 req=%0b", tag, hs4.pend_cnt, hs4.req_o, m_phase == 1);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            hs4.evt_pulse = 1'($urandom_range(1));
            hs4.ack_i = 1'($urandom_range(1));
            hs4.ovf_clr = 1'($urandom_range(1));
            hs2.evt_pulse = 1'($urandom_range(1));
            hs2.ack_i = 1'($urandom_range(1));
            hs2.ovf_clr = 1'($urandom_range(1));
            tick();
            tests++;
            if ({hs4.req_o, hs4.busy, hs4.ovf} !== 3'b000 || hs4.pend_cnt !== 4'd0) begin
                fails++;
                $display("FAIL reset_u4: req=%0b busy=%0b ovf=%0b pend=%0d, want all 0", hs4.req_o, hs4.busy, hs4.ovf, hs4.pend_cnt);
            end
            tests++;
            if ({hs2.req_o, hs2.busy, hs2.ovf} !== 3'b000 || hs2.pend_cnt !== 2'd0) begin
                fails++;
                $display("FAIL reset_u2: req=%0b busy=%0b ovf=%0b pend=%0d, want all 0", hs2.req_o, hs2.busy, hs2.ovf, hs2.pend_cnt);
            end
        end
        hs4.evt_pulse = 1'b0;
        hs4.ovf_clr = 1'b0;
        hs4.ack_i = 1'b1;
        hs2.evt_pulse = 1'b0;
        hs2.ovf_clr = 1'b0;
        hs2.ack_i = 1'b0;
        tick();
        rstn = 1'b1;
        stale_ack_release("reset");
    endtask

    task automatic test_single();
        int rise = -1;
        int fall = -1;
        int k = -1;
        int n = 0;
        logic prev;
        hs4.evt_pulse = 1'b1;
        prev = hs4.req_o;
        for (int c = 1; c <= 60; c++) begin
            tick();
            hs4.evt_pulse = 1'b0;
            if (c == 1) begin
                tests++;
                if (hs4.pend_cnt !== 4'd1 || hs4.req_o !== 1'b0) begin
                    fails++;
                    $display("FAIL single_c1: pend=%0d req=%0b, want pend=1 req=0", hs4.pend_cnt, hs4.req_o);
                end
            end
            if (hs4.req_o && !prev) begin
                n++;
                if (rise < 0) rise = c;
            end
            if (!hs4.req_o && prev && fall < 0) fall = c;
            if (hs4.ack_i && k < 0) k = c;
            prev = hs4.req_o;
        end
        tests++;
        if (rise !== 2) begin
            fails++;
            $display("FAIL single_rise: req rose in cycle %0d, want 2", rise);
        end
        tests++;
        if (fall - k !== 4) begin
            fails++;
            $display("FAIL single_fall: req fell %0d cycles after ack, want 4", fall - k);
        end
        tests++;
        if (n !== 1 || hs4.busy !== 1'b0 || hs4.pend_cnt !== 4'd0) begin
            fails++;
            $display("FAIL single_done: handshakes=%0d busy=%0b pend=%0d, want 1/0/0", n, hs4.busy, hs4.pend_cnt);
        end
    endtask

    task automatic test_burst();
        int peak = 0;
        int rises = 0;
        logic prev;
        prev = hs4.req_o;
        for (int c = 0; c < 400; c++) begin
            hs4.evt_pulse = (c < 6);
            tick();
            if (hs4.pend_cnt > peak) peak = hs4.pend_cnt;
            if (hs4.req_o && !prev) rises++;
            prev = hs4.req_o;
            tests++;
            if (hs4.pend_cnt !== 4'(m_cnt) || hs4.req_o !== (m_phase == 1)) begin
                fails++;
                $display("FAIL burst_model: cycle %0d pend=%0d req=%0b, want pend=%0d req=%0b", c, hs4.pend_cnt, hs4.req_o, m_cnt, m_phase == 1);
            end
            if (c > 6 && !hs4.busy) break;
        end
        hs4.evt_pulse = 1'b0;
        tests++;
        if (peak !== 5) begin
            fails++;
            $display("FAIL burst_peak: pend peaked at %0d, want 5", peak);
        end
        tests++;
        if (rises !== 6 || hs4.busy !== 1'b0 || hs4.pend_cnt !== 4'd0 || hs4.ovf !== 1'b0) begin
            fails++;
            $display("FAIL burst_done: handshakes=%0d busy=%0b pend=%0d ovf=%0b, want 6/0/0/0", rises, hs4.busy, hs4.pend_cnt, hs4.ovf);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            hs4.evt_pulse = ($urandom_range(2) == 0);
            hs4.ovf_clr = ($urandom_range(7) == 0);
            tick();
            tests++;
            if (hs4.req_o !== (m_phase == 1) || hs4.busy !== (m_phase != 0 || m_cnt != 0) ||
                hs4.ovf !== m_ovf || hs4.pend_cnt !== 4'(m_cnt)) begin
                fails++;
                $display("FAIL random_model: cycle %0d req=%0b busy=%0b ovf=%0b pend=%0d, want %0b/%0b/%0b/%0d",
                         c, hs4.req_o, hs4.busy, hs4.ovf, hs4.pend_cnt,
                         m_phase == 1, m_phase != 0 || m_cnt != 0, m_ovf, m_cnt);
            end
        end
        hs4.evt_pulse = 1'b0;
        hs4.ovf_clr = 1'b1;
        tick();
        hs4.ovf_clr = 1'b0;
        tests++;
        if (hs4.ovf !== 1'b0) begin
            fails++;
            $display("FAIL random_clr: ovf=%0b, want 0", hs4.ovf);
        end
    endtask

    task automatic test_overflow();
        hs2.ack_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            hs2.evt_pulse = 1'b1;
            tick();
            if (i == 3) begin
                tests++;
                if (hs2.pend_cnt !== 2'd3 || hs2.ovf !== 1'b0) begin
                    fails++;
                    $display("FAIL ovf_fill: pend=%0d ovf=%0b, want pend=3 ovf=0", hs2.pend_cnt, hs2.ovf);
                end
            end
        end
        hs2.evt_pulse = 1'b0;
        tests++;
        if (hs2.pend_cnt !== 2'd3 || hs2.ovf !== 1'b1 || hs2.req_o !== 1'b1) begin
            fails++;
            $display("FAIL ovf_sat: pend=%0d ovf=%0b req=%0b, want 3/1/1", hs2.pend_cnt, hs2.ovf, hs2.req_o);
        end
        hs2.ovf_clr = 1'b1;
        hs2.evt_pulse = 1'b1;
        tick();
        hs2.evt_pulse = 1'b0;
        tests++;
        if (hs2.ovf !== 1'b1 || hs2.pend_cnt !== 2'd3) begin
            fails++;
            $display("FAIL ovf_set_wins: ovf=%0b pend=%0d, want ovf=1 pend=3", hs2.ovf, hs2.pend_cnt);
        end
        tick();
        hs2.ovf_clr = 1'b0;
        tests++;
        if (hs2.ovf !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clear: ovf=%0b, want 0", hs2.ovf);
        end
    endtask

    task automatic test_sim_max();
        int c = 0;
        hs2.ack_i = 1'b1;
        while (hs2.req_o && c < 20) begin
            tick();
            c++;
        end
        tests++;
        if (hs2.req_o !== 1'b0) begin
            fails++;
            $display("FAIL simmax_ack: req=%0b after %0d cycles of ack, want 0", hs2.req_o, c);
        end
        hs2.ack_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        tests++;
        if (hs2.req_o !== 1'b0 || hs2.pend_cnt !== 2'd3) begin
            fails++;
            $display("FAIL simmax_pre: req=%0b pend=%0d, want req=0 pend=3", hs2.req_o, hs2.pend_cnt);
        end
        hs2.evt_pulse = 1'b1;
        tick();
        hs2.evt_pulse = 1'b0;
        tests++;
        if (hs2.pend_cnt !== 2'd3 || hs2.ovf !== 1'b0 || hs2.req_o !== 1'b1) begin
            fails++;
            $display("FAIL simmax_launch: pend=%0d ovf=%0b req=%0b, want 3/0/1", hs2.pend_cnt, hs2.ovf, hs2.req_o);
        end
    endtask

    task automatic test_reset_mid();
        resp_on = 1'b0;
        hs4.ack_i = 1'b0;
        hs4.evt_pulse = 1'b1;
        tick();
        hs4.evt_pulse = 1'b0;
        tick();
        tests++;
        if (hs4.req_o !== 1'b1) begin
            fails++;
            $display("FAIL mid_req: req=%0b, want 1", hs4.req_o);
        end
        hs4.ack_i = 1'b1;
        hs4.evt_pulse = 1'b1;
        tick();
        hs4.evt_pulse = 1'b0;
        rstn = 1'b0;
        model_reset();
        #1;
        tests++;
        if (hs4.req_o !== 1'b0 || hs4.pend_cnt !== 4'd0 || hs4.busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_async: req=%0b pend=%0d busy=%0b, want all 0", hs4.req_o, hs4.pend_cnt, hs4.busy);
        end
        tick();
        tick();
        rstn = 1'b1;
        stale_ack_release("mid");
    endtask

    initial begin
        hs4.evt_pulse = 1'b0;
        hs4.ack_i = 1'b0;
        hs4.ovf_clr = 1'b0;
        hs2.evt_pulse = 1'b0;
        hs2.ack_i = 1'b0;
        hs2.ovf_clr = 1'b0;
        model_reset();
        test_reset();
        drain();
        test_single();
        drain();
        test_burst();
        drain();
        test_random();
        drain();
        test_overflow();
        test_sim_max();
        test_reset_mid();
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
